// File: rtl/keys_debounce_pkg.sv
// -----------------------------------------------------------------------------
// keys_pkg
// Shared definitions for the key conditioning block (keys_debounce):
//   - key_state_t  : per-channel FSM state encoding
//   - GAP_CYCLES   : length of the high gap inserted before each auto-repeat edge
//   - KEY_RELEASED : level of a released (idle) active-low key
//   - max_u / cnt_width : constant helpers used to size the channel counters
// -----------------------------------------------------------------------------
package keys_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2,
    GAP      = 2'd3
  } key_state_t;

  // The PIO edge detector is two flops deep, so it needs at least three high
  // cycles to see the next falling edge; four leaves one cycle of margin.
  localparam int unsigned GAP_CYCLES = 32'd4;

  localparam logic KEY_RELEASED = 1'b1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n > 32'd1) begin
      return $clog2(n);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/keys_debounce_chan.sv
// -----------------------------------------------------------------------------
// keys_debounce_chan
// One key channel: two-flop synchronizer, consecutive-sample debounce, and a
// RELEASED/PRESSED/HELD(/GAP) FSM producing the PIO level, a press strobe and
// a long-press flag. Auto-repeat (GAP state) is compiled in only when the
// macro KEYS_DEBOUNCE_REPEAT_EN is defined.
//
// Ports:
//   clk        in  : system clock
//   reset_n    in  : asynchronous active-low reset
//   key_n_raw  in  : raw active-low button, asynchronous to clk
//   key_out    out : debounced active-low level (with repeat gaps), registered
//   key_press  out : one-cycle strobe per accepted press / repeat, registered
//   key_held   out : high while the key is in the long-press state, registered
// -----------------------------------------------------------------------------
module keys_debounce_chan
  import keys_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1000000,
  parameter int unsigned HOLD_CYCLES     = 32'd50000000,
  parameter int unsigned REPEAT_CYCLES   = 32'd10000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n_raw,
  output logic key_out,
  output logic key_press,
  output logic key_held
);

  localparam int unsigned DCNT_W = cnt_width(DEBOUNCE_CYCLES);
  // GAP_CYCLES is folded in only so the gap count always fits; for any sane
  // configuration the hold/repeat terms dominate.
  localparam int unsigned HCNT_W =
    cnt_width(max_u(max_u(HOLD_CYCLES, REPEAT_CYCLES), GAP_CYCLES));

  localparam logic [DCNT_W-1:0] DCNT_ZERO = {DCNT_W{1'b0}};
  localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(32'd1);
  localparam logic [DCNT_W-1:0] DCNT_MAX  = DCNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [HCNT_W-1:0] HCNT_ZERO = {HCNT_W{1'b0}};
  localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(32'd1);
  localparam logic [HCNT_W-1:0] HOLD_MAX  = HCNT_W'(HOLD_CYCLES - 32'd1);
`ifdef KEYS_DEBOUNCE_REPEAT_EN
  localparam logic [HCNT_W-1:0] REP_MAX   = HCNT_W'(REPEAT_CYCLES - 32'd1);
  localparam logic [HCNT_W-1:0] GAP_MAX   = HCNT_W'(GAP_CYCLES - 32'd1);
`endif

  logic              s1_r;
  logic              s2_r;
  logic              deb_r;
  logic              deb_nxt_s;
  logic [DCNT_W-1:0] dcnt_r;
  logic [DCNT_W-1:0] dcnt_nxt_s;

  key_state_t        state_r;
  key_state_t        state_nxt_s;
  logic [HCNT_W-1:0] hcnt_r;
  logic [HCNT_W-1:0] hcnt_nxt_s;
  logic              out_r;
  logic              out_nxt_s;
  logic              press_r;
  logic              press_nxt_s;
  logic              held_r;
  logic              held_nxt_s;

  // Two-flop synchronizer; resets to the released level so no edge is faked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_r <= KEY_RELEASED;
      s2_r <= KEY_RELEASED;
    end else begin
      s1_r <= key_n_raw;
      s2_r <= s1_r;
    end
  end

  // Debounce: count consecutive disagreeing samples, flip after DEBOUNCE_CYCLES.
  always_comb begin
    deb_nxt_s  = deb_r;
    dcnt_nxt_s = dcnt_r;
    if (s2_r == deb_r) begin
      dcnt_nxt_s = DCNT_ZERO;
    end else if (dcnt_r == DCNT_MAX) begin
      deb_nxt_s  = s2_r;
      dcnt_nxt_s = DCNT_ZERO;
    end else begin
      dcnt_nxt_s = dcnt_r + DCNT_ONE;
    end
  end

  // Debounced level and its counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_r  <= KEY_RELEASED;
      dcnt_r <= DCNT_ZERO;
    end else begin
      deb_r  <= deb_nxt_s;
      dcnt_r <= dcnt_nxt_s;
    end
  end

  // Key FSM next state and registered-output values. A debounced release is
  // checked first so it overrides every other transition, including gap end.
  always_comb begin
    state_nxt_s = state_r;
    hcnt_nxt_s  = hcnt_r;
    out_nxt_s   = out_r;
    press_nxt_s = 1'b0;
    held_nxt_s  = held_r;
    if (deb_r == KEY_RELEASED) begin
      state_nxt_s = RELEASED;
      hcnt_nxt_s  = HCNT_ZERO;
      out_nxt_s   = KEY_RELEASED;
      held_nxt_s  = 1'b0;
    end else begin
      case (state_r)
        RELEASED: begin
          state_nxt_s = PRESSED;
          hcnt_nxt_s  = HCNT_ZERO;
          out_nxt_s   = ~KEY_RELEASED;
          press_nxt_s = 1'b1;
        end
        PRESSED: begin
          if (hcnt_r == HOLD_MAX) begin
            state_nxt_s = HELD;
            held_nxt_s  = 1'b1;
            hcnt_nxt_s  = HCNT_ZERO;
          end else begin
            hcnt_nxt_s  = hcnt_r + HCNT_ONE;
          end
        end
        HELD: begin
`ifdef KEYS_DEBOUNCE_REPEAT_EN
          if (hcnt_r == REP_MAX) begin
            state_nxt_s = GAP;
            out_nxt_s   = KEY_RELEASED;
            hcnt_nxt_s  = HCNT_ZERO;
          end else begin
            hcnt_nxt_s  = hcnt_r + HCNT_ONE;
          end
`else
          // Terminal until release; the counter just parks at its limit.
          if (hcnt_r != HOLD_MAX) begin
            hcnt_nxt_s = hcnt_r + HCNT_ONE;
          end else begin
            hcnt_nxt_s = hcnt_r;
          end
`endif
        end
`ifdef KEYS_DEBOUNCE_REPEAT_EN
        GAP: begin
          if (hcnt_r == GAP_MAX) begin
            state_nxt_s = HELD;
            out_nxt_s   = ~KEY_RELEASED;
            press_nxt_s = 1'b1;
            hcnt_nxt_s  = HCNT_ZERO;
          end else begin
            hcnt_nxt_s  = hcnt_r + HCNT_ONE;
          end
        end
`endif
        default: begin
          state_nxt_s = RELEASED;
          hcnt_nxt_s  = HCNT_ZERO;
          out_nxt_s   = KEY_RELEASED;
          held_nxt_s  = 1'b0;
        end
      endcase
    end
  end

  // FSM state, hold counter and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= RELEASED;
      hcnt_r  <= HCNT_ZERO;
      out_r   <= KEY_RELEASED;
      press_r <= 1'b0;
      held_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      hcnt_r  <= hcnt_nxt_s;
      out_r   <= out_nxt_s;
      press_r <= press_nxt_s;
      held_r  <= held_nxt_s;
    end
  end

  assign key_out   = out_r;
  assign key_press = press_r;
  assign key_held  = held_r;

endmodule

// File: rtl/keys_debounce.sv
// -----------------------------------------------------------------------------
// keys_debounce
// Conditions raw active-low push buttons for the key PIO in_port: per key a
// synchronizer, debounce, long-press detection and (optionally) auto-repeat.
// Channels are fully independent; this level only slices the buses.
// Optional feature macro: KEYS_DEBOUNCE_REPEAT_EN (auto-repeat while held).
//
// Ports:
//   clk        in  1        : system clock
//   reset_n    in  1        : asynchronous active-low reset
//   keys_n_in  in  NUM_KEYS : raw active-low buttons, asynchronous to clk
//   key_out    out NUM_KEYS : debounced active-low level with repeat gaps
//   key_press  out NUM_KEYS : one-cycle strobe per accepted press / repeat
//   key_held   out NUM_KEYS : high while a key is in the long-press state
// -----------------------------------------------------------------------------
module keys_debounce
  import keys_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 32'd4,
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1000000,
  parameter int unsigned HOLD_CYCLES     = 32'd50000000,
  parameter int unsigned REPEAT_CYCLES   = 32'd10000000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] keys_n_in,
  output logic [NUM_KEYS-1:0] key_out,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_held
);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
    keys_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .key_n_raw (keys_n_in[k]),
      .key_out   (key_out[k]),
      .key_press (key_press[k]),
      .key_held  (key_held[k])
    );
  end

endmodule

// File: tb/tb_keys_debounce.sv
// -----------------------------------------------------------------------------
// tb_keys_debounce
// Directed bench for keys_debounce with DEBOUNCE_CYCLES=8, HOLD_CYCLES=32,
// REPEAT_CYCLES=16. Inputs change on the falling clock edge; outputs are read
// 1 time unit after the rising edge. Repeat checks follow
// KEYS_DEBOUNCE_REPEAT_EN.
// -----------------------------------------------------------------------------
module tb_keys_debounce;

  localparam int unsigned NK   = 32'd4;
  localparam int unsigned DEB  = 32'd8;
  localparam int unsigned HOLD = 32'd32;
  localparam int unsigned REP  = 32'd16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NK-1:0] keys_n_in;
  logic [NK-1:0] key_out;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_held;

  int checks = 0;
  int errors = 0;

  int press_cnt [NK] = '{default: 0};
  int fall_cnt  [NK] = '{default: 0};
  int rise_cnt  [NK] = '{default: 0};
  int align_err = 0;
  logic [NK-1:0] prev_out = 4'hF;

  always #5 clk = ~clk;

  keys_debounce #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .keys_n_in (keys_n_in),
    .key_out   (key_out),
    .key_press (key_press),
    .key_held  (key_held)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Per-cycle bookkeeping of strobes and output edges; a strobe must coincide
  // exactly with a falling key_out.
  always @(negedge clk) begin
    for (int k = 0; k < NK; k++) begin
      if (key_press[k] === 1'b1) press_cnt[k] <= press_cnt[k] + 1;
      if (prev_out[k] === 1'b1 && key_out[k] === 1'b0) fall_cnt[k] <= fall_cnt[k] + 1;
      if (prev_out[k] === 1'b0 && key_out[k] === 1'b1) rise_cnt[k] <= rise_cnt[k] + 1;
      if (key_press[k] !== (prev_out[k] & ~key_out[k])) align_err <= align_err + 1;
    end
    prev_out <= key_out;
  end

  // Count rising edges until key_out[k] (sel=0) or key_held[k] (sel=1) equals
  // lvl; n=-1 when the bound expires.
  task automatic edges_until(input int k, input int sel, input logic lvl, output int n);
    logic v;
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      v = (sel == 0) ? key_out[k] : key_held[k];
      if (v === lvl) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int p0;
    int p1;
    int f1;
    int p2;
    int f2;
    int r2;
    int p3;
    int p3b;
    int r3;

    keys_n_in = 4'hF;
    reset_n   = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_key_out", key_out, 4'hF);
    check_eq("rst_key_press", key_press, 4'h0);
    check_eq("rst_key_held", key_held, 4'h0);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_eq("idle_key_out", key_out, 4'hF);

    // Clean press/release on key0: edge count includes the sampling edge.
    p0 = press_cnt[0];
    @(negedge clk);
    keys_n_in[0] = 1'b0;
    edges_until(0, 0, 1'b0, n);
    check_eq("press_lat", n - 1, 10);
    check_eq("press_strobe", key_press[0], 1'b1);
    @(posedge clk);
    #1;
    check_eq("press_one_cycle", key_press[0], 1'b0);
    @(negedge clk);
    keys_n_in[0] = 1'b1;
    edges_until(0, 0, 1'b1, n);
    check_eq("release_lat", n - 1, 10);
    repeat (3) @(posedge clk);
    #1;
    check_eq("press_count_k0", press_cnt[0] - p0, 1);

    // Bounce on key1: 3-cycle runs never reach 8 consecutive samples.
    p1 = press_cnt[1];
    f1 = fall_cnt[1];
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      keys_n_in[1] = (((i / 3) % 2) == 1) ? 1'b1 : 1'b0;
    end
    check_eq("bounce_quiet", key_out, 4'hF);
    @(negedge clk);
    keys_n_in[1] = 1'b0;
    edges_until(1, 0, 1'b0, n);
    check_eq("bounce_settle_lat", n - 1, 10);
    repeat (3) @(posedge clk);
    #1;
    check_eq("bounce_falls", fall_cnt[1] - f1, 1);
    check_eq("bounce_presses", press_cnt[1] - p1, 1);
    @(negedge clk);
    keys_n_in[1] = 1'b1;
    edges_until(1, 0, 1'b1, n);
    check_eq("bounce_release_lat", n - 1, 10);

    // Glitch on key2: 7 low cycles rejected, 8 low cycles accepted.
    p2 = press_cnt[2];
    @(negedge clk);
    keys_n_in[2] = 1'b0;
    repeat (7) @(negedge clk);
    keys_n_in[2] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_eq("glitch7_key_out", key_out, 4'hF);
    check_eq("glitch7_presses", press_cnt[2] - p2, 0);
    f2 = fall_cnt[2];
    r2 = rise_cnt[2];
    @(negedge clk);
    keys_n_in[2] = 1'b0;
    repeat (8) @(negedge clk);
    keys_n_in[2] = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check_eq("pulse8_falls", fall_cnt[2] - f2, 1);
    check_eq("pulse8_rises", rise_cnt[2] - r2, 1);
    check_eq("pulse8_key_out", key_out, 4'hF);

    // Long press on key3.
    p3 = press_cnt[3];
    @(negedge clk);
    keys_n_in[3] = 1'b0;
    edges_until(3, 0, 1'b0, n);
    check_eq("k3_press_lat", n - 1, 10);
    edges_until(3, 1, 1'b1, n);
    check_eq("k3_held_delay", n, 32);
`ifdef KEYS_DEBOUNCE_REPEAT_EN
    edges_until(3, 0, 1'b1, n);
    check_eq("gap1_start", n, 16);
    edges_until(3, 0, 1'b0, n);
    check_eq("gap1_len", n, 4);
    check_eq("gap1_strobe", key_press[3], 1'b1);
    edges_until(3, 0, 1'b1, n);
    check_eq("gap2_start", n, 16);
    edges_until(3, 0, 1'b0, n);
    check_eq("gap2_len", n, 4);
    check_eq("gap2_strobe", key_press[3], 1'b1);
    @(posedge clk);
    #1;
    p3b = press_cnt[3];
    r3  = rise_cnt[3];
    check_eq("repeat_presses", p3b - p3, 3);
    // Release debounced exactly on the last gap cycle: release must win.
    repeat (8) @(posedge clk);
    @(negedge clk);
    keys_n_in[3] = 1'b1;
    edges_until(3, 1, 1'b0, n);
    check_eq("gap_release_lat", n - 1, 10);
    check_eq("gap_release_key_out", key_out[3], 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check_eq("gap_release_no_pulse", press_cnt[3] - p3b, 0);
    check_eq("gap_release_rises", rise_cnt[3] - r3, 1);
    check_eq("gap_release_out_hi", key_out[3], 1'b1);
`else
    r3 = rise_cnt[3];
    repeat (40) @(posedge clk);
    #1;
    check_eq("hold_key_out_low", key_out[3], 1'b0);
    check_eq("hold_no_gaps", rise_cnt[3] - r3, 0);
    check_eq("hold_still_held", key_held[3], 1'b1);
    check_eq("hold_one_press", press_cnt[3] - p3, 1);
    @(negedge clk);
    keys_n_in[3] = 1'b1;
    edges_until(3, 0, 1'b1, n);
    check_eq("hold_release_lat", n - 1, 10);
    p3b = press_cnt[3];
    check_eq("hold_release_presses", p3b - p3, 1);
`endif
    check_eq("k3_held_cleared", key_held[3], 1'b0);

    // Reset while key0 is held, key kept down through reset.
    @(negedge clk);
    keys_n_in[0] = 1'b0;
    edges_until(0, 0, 1'b0, n);
    check_eq("k0_press_lat", n - 1, 10);
    edges_until(0, 1, 1'b1, n);
    check_eq("k0_held_delay", n, 32);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_key_out", key_out, 4'hF);
    check_eq("midrst_key_held", key_held, 4'h0);
    check_eq("midrst_key_press", key_press, 4'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    edges_until(0, 0, 1'b0, n);
    check_eq("repress_lat", n - 1, 10);
    check_eq("repress_strobe", key_press[0], 1'b1);
    @(negedge clk);
    keys_n_in[0] = 1'b1;
    edges_until(0, 0, 1'b1, n);
    check_eq("final_release_lat", n - 1, 10);
    repeat (2) @(posedge clk);
    #1;
    check_eq("strobe_align", align_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
